// File: rtl/rr_parallel_finder.sv
// Registered round-robin multi-grant finder: scans req circularly from ptr and
// returns up to GRANT_NUM set-bit indices, nearest first, one cycle later.
module rr_parallel_finder #(
    parameter int WIDTH     = 8,
    parameter int GRANT_NUM = 2,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           req,
    input  logic                       req_valid,
    input  logic                       stall,
    input  logic                       flush,
    output logic [GRANT_NUM*IDX_W-1:0] grant_index,
    output logic [GRANT_NUM-1:0]       grant_valid,
    output logic [WIDTH-1:0]           grant_mask,
    output logic [IDX_W-1:0]           ptr
);

    // One extra bit so ptr+offset can exceed WIDTH before the wrap subtract.
    localparam int SUM_W = IDX_W + 1;

    // Control contract: flush beats stall beats the normal update; req is only
    // looked at when req_valid is high and the block is not stalled.

    logic [GRANT_NUM*IDX_W-1:0] nxt_index;
    logic [GRANT_NUM-1:0]       nxt_valid;
    logic [WIDTH-1:0]           nxt_mask;
    logic [IDX_W-1:0]           nxt_ptr;
    logic [SUM_W-1:0]           sum;
    logic [SUM_W-1:0]           next_start;
    logic [IDX_W-1:0]           pos;
    logic [IDX_W-1:0]           last;
    int                         cnt;

    always_comb begin
        nxt_index  = '0;
        nxt_valid  = '0;
        nxt_mask   = '0;
        nxt_ptr    = ptr;
        sum        = '0;
        next_start = '0;
        pos        = '0;
        last       = '0;
        cnt        = 0;
        if (req_valid) begin
            for (int o = 0; o < WIDTH; o++) begin
                sum = {1'b0, ptr} + SUM_W'(o);
                if (sum >= SUM_W'(WIDTH))
                    sum = sum - SUM_W'(WIDTH);
                pos = sum[IDX_W-1:0];
                if (req[pos] && (cnt < GRANT_NUM)) begin
                    for (int k = 0; k < GRANT_NUM; k++) begin
                        if (cnt == k) begin
                            nxt_index[k*IDX_W +: IDX_W] = pos;
                            nxt_valid[k]                = 1'b1;
                        end
                    end
                    nxt_mask[pos] = 1'b1;
                    last          = pos;
                    cnt           = cnt + 1;
                end
            end
            if (cnt > 0) begin
                next_start = {1'b0, last} + SUM_W'(1);
                if (next_start >= SUM_W'(WIDTH))
                    next_start = '0;
                nxt_ptr = next_start[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_index <= '0;
            grant_valid <= '0;
            grant_mask  <= '0;
            ptr         <= '0;
        end else if (flush) begin
            grant_index <= '0;
            grant_valid <= '0;
            grant_mask  <= '0;
            ptr         <= '0;
        end else if (!stall) begin
            grant_index <= nxt_index;
            grant_valid <= nxt_valid;
            grant_mask  <= nxt_mask;
            ptr         <= nxt_ptr;
        end
    end

endmodule

// File: tb/tb_rr_parallel_finder.sv
// Bench for rr_parallel_finder: an 8-bit/2-grant and a 6-bit/3-grant instance
// checked against a queue-based circular-scan model.
module tb_rr_parallel_finder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       stall;
    logic       flush;

    logic [7:0] req_a;
    logic [5:0] ga_index;
    logic [1:0] ga_valid;
    logic [7:0] ga_mask;
    logic [2:0] ga_ptr;

    logic [5:0] req_b;
    logic [8:0] gb_index;
    logic [2:0] gb_valid;
    logic [5:0] gb_mask;
    logic [2:0] gb_ptr;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0] idx;
        logic [7:0]  val;
        logic [7:0]  mask;
        logic [31:0] ptr;
    } mstate_t;

    mstate_t ma, mb;

    // clock / reset
    always #5 clk = ~clk;

    rr_parallel_finder #(.WIDTH(8), .GRANT_NUM(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_valid(req_valid),
        .stall(stall), .flush(flush), .grant_index(ga_index),
        .grant_valid(ga_valid), .grant_mask(ga_mask), .ptr(ga_ptr)
    );

    rr_parallel_finder #(.WIDTH(6), .GRANT_NUM(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_valid(req_valid),
        .stall(stall), .flush(flush), .grant_index(gb_index),
        .grant_valid(gb_valid), .grant_mask(gb_mask), .ptr(gb_ptr)
    );

    // reference model: collect set positions in circular order, keep the first gn
    function automatic mstate_t rr_next(input int w, input int gn, input int idw,
                                        input mstate_t s, input logic [7:0] r,
                                        input bit rv, input bit st, input bit fl);
        mstate_t n;
        int      q[$];
        int      idx;
        n = s;
        if (fl) begin
            n = '0;
        end else if (!st) begin
            n.idx  = '0;
            n.val  = '0;
            n.mask = '0;
            if (rv) begin
                for (int d = 0; d < w; d++) begin
                    idx = (int'(s.ptr) + d) % w;
                    if (r[idx]) q.push_back(idx);
                end
                for (int k = 0; k < gn && k < q.size(); k++) begin
                    n.idx       = n.idx | (32'(q[k]) << (k * idw));
                    n.val[k]    = 1'b1;
                    n.mask[q[k]] = 1'b1;
                    n.ptr       = 32'((q[k] + 1) % w);
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_expected();
        exp_q.push_back(ma.idx);
        exp_q.push_back(32'(ma.val));
        exp_q.push_back(32'(ma.mask));
        exp_q.push_back(ma.ptr);
        exp_q.push_back(mb.idx);
        exp_q.push_back(32'(mb.val));
        exp_q.push_back(32'(mb.mask));
        exp_q.push_back(mb.ptr);
    endtask

    task automatic check_all();
        check("a_index", 32'(ga_index), exp_q.pop_front());
        check("a_valid", 32'(ga_valid), exp_q.pop_front());
        check("a_mask",  32'(ga_mask),  exp_q.pop_front());
        check("a_ptr",   32'(ga_ptr),   exp_q.pop_front());
        check("b_index", 32'(gb_index), exp_q.pop_front());
        check("b_valid", 32'(gb_valid), exp_q.pop_front());
        check("b_mask",  32'(gb_mask),  exp_q.pop_front());
        check("b_ptr",   32'(gb_ptr),   exp_q.pop_front());
    endtask

    // driver: called at a falling edge, returns at the next falling edge
    task automatic step(input logic [7:0] ra, input logic [5:0] rb,
                        input bit rv, input bit st, input bit fl);
        req_a     = ra;
        req_b     = rb;
        req_valid = rv;
        stall     = st;
        flush     = fl;
        ma = rr_next(8, 2, 3, ma, ra, rv, st, fl);
        mb = rr_next(6, 3, 3, mb, {2'b00, rb}, rv, st, fl);
        push_expected();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        ma  = '0;
        mb  = '0;
        #1;
        push_expected();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        ma        = '0;
        mb        = '0;
        repeat (2) @(negedge clk);
        push_expected();
        check_all();
        rst = 1'b0;

        // 1: first grants and pointer advance; B moves its pointer to 4
        step(8'b0000_0110, 6'b00_1000, 1, 0, 0);
        check("t1_index", 32'(ga_index), 32'd17);
        check("t1_valid", 32'(ga_valid), 32'h3);
        check("t1_mask",  32'(ga_mask),  32'h06);
        check("t1_ptr",   32'(ga_ptr),   32'd3);

        // 2: wrap-around fairness; 6: non-power-of-two wrap on B
        step(8'b1000_1001, 6'b11_0011, 1, 0, 0);
        check("t6_index", 32'(gb_index), 32'd44);
        check("t6_valid", 32'(gb_valid), 32'h7);
        check("t6_ptr",   32'(gb_ptr),   32'd1);
        step(8'b1000_1001, 6'b11_0011, 1, 0, 0);

        // 3: partial, empty and not-valid requests
        step(8'b0001_0000, 6'b00_0001, 1, 0, 0);
        step(8'h00, 6'h00, 1, 0, 0);
        step(8'hFF, 6'h3F, 0, 0, 0);

        // 4: stall holds everything while req churns
        step(8'h00, 6'h00, 0, 0, 1);
        step(8'b0000_0110, 6'b00_0110, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(8'($urandom), 6'($urandom), 1'($urandom), 1, 0);
        step(8'b1000_0001, 6'b10_0001, 1, 0, 0);

        // 5: flush wins over stall; async reset mid-cycle
        step(8'b0011_0000, 6'b01_1000, 1, 0, 0);
        step(8'($urandom), 6'($urandom), 1, 1, 1);
        step(8'b1111_0000, 6'b11_1000, 1, 0, 0);
        async_reset();

        // all-ones request on B (3 of 6) and A
        step(8'hFF, 6'h3F, 1, 0, 0);
        step(8'hFF, 6'h3F, 1, 0, 0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 6'($urandom),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 19) == 0);
            if (i % 97 == 50) begin
                step(8'($urandom) | 8'h01, 6'($urandom) | 6'h01, 1, 0, 0);
                async_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
